// File: rtl/lfsr_prbs_pkg.sv
// Shared types and helpers for the PRBS checker: FSM states, fill-length
// calculation and a bit population count.
package lfsr_prbs_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } prbs_state_e;

    function automatic int fill_words(input int lfsr_width, input int data_width);
        return (lfsr_width + data_width - 32'sd1) / data_width;
    endfunction

    function automatic logic [6:0] popcount(input logic [63:0] value);
        logic [6:0] cnt;
        cnt = 7'd0;
        for (int i = 0; i < 64; i++) begin
            cnt = cnt + {6'd0, value[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/lfsr_prbs_check_if.sv
// Control, data and status bundle of the PRBS checker; the checker is the
// slave, the word source / status consumer is the master.
interface lfsr_prbs_check_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 32
);
    logic                  enable;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_in_valid;
    logic                  clear_counts;
    logic                  locked;
    logic                  word_error;
    logic [DATA_WIDTH-1:0] err_bits;
    logic [CNT_WIDTH-1:0]  err_count;
    logic [CNT_WIDTH-1:0]  word_count;

    modport master (
        output enable, data_in, data_in_valid, clear_counts,
        input  locked, word_error, err_bits, err_count, word_count
    );

    modport slave (
        input  enable, data_in, data_in_valid, clear_counts,
        output locked, word_error, err_bits, err_count, word_count
    );
endinterface

// File: rtl/lfsr.sv
// Combinational LFSR step engine: advances the state by DATA_WIDTH bits (MSB
// first) in Fibonacci or Galois form, optionally as a self-synchronising
// feed-forward descrambler.
module lfsr #(
    parameter int                    LFSR_WIDTH        = 9,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 9'h021,
    parameter                        LFSR_CONFIG       = "FIBONACCI",
    parameter bit                    LFSR_FEED_FORWARD = 1'b0,
    parameter bit                    REVERSE           = 1'b0,
    parameter int                    DATA_WIDTH        = 8
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [LFSR_WIDTH-1:0] state_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [LFSR_WIDTH-1:0] state_out
);

    localparam bit GALOIS = (LFSR_CONFIG == "GALOIS");
    // Fibonacci feedback: top stage plus stage j-1 for every polynomial term j.
    localparam logic [LFSR_WIDTH-1:0] FIB_TAPS =
        {1'b1, {(LFSR_WIDTH-1){1'b0}}} | (LFSR_POLY >> 1);
    localparam logic [LFSR_WIDTH-1:0] GAL_TAPS = LFSR_POLY | {{(LFSR_WIDTH-1){1'b0}}, 1'b1};

    logic [LFSR_WIDTH-1:0] st_v;
    logic [DATA_WIDTH-1:0] din_v;
    logic [DATA_WIDTH-1:0] dout_v;
    logic                  fb_v;
    logic                  tap_v;

    // Bit-serial unroll of DATA_WIDTH shifts.
    always_comb begin
        st_v   = {LFSR_WIDTH{1'b0}};
        din_v  = {DATA_WIDTH{1'b0}};
        dout_v = {DATA_WIDTH{1'b0}};
        fb_v   = 1'b0;
        tap_v  = 1'b0;
        for (int k = 0; k < LFSR_WIDTH; k++) begin
            st_v[k] = REVERSE ? state_in[LFSR_WIDTH-1-k] : state_in[k];
        end
        for (int k = 0; k < DATA_WIDTH; k++) begin
            din_v[k] = REVERSE ? data_in[DATA_WIDTH-1-k] : data_in[k];
        end
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (GALOIS) begin
                fb_v  = st_v[LFSR_WIDTH-1] ^ din_v[i];
                tap_v = LFSR_FEED_FORWARD ? din_v[i] : fb_v;
                st_v  = {st_v[LFSR_WIDTH-2:0], 1'b0} ^ ({LFSR_WIDTH{tap_v}} & GAL_TAPS);
            end else begin
                fb_v  = (^(st_v & FIB_TAPS)) ^ din_v[i];
                tap_v = LFSR_FEED_FORWARD ? din_v[i] : fb_v;
                st_v  = {st_v[LFSR_WIDTH-2:0], tap_v};
            end
            dout_v[i] = fb_v;
        end
        for (int k = 0; k < LFSR_WIDTH; k++) begin
            state_out[k] = REVERSE ? st_v[LFSR_WIDTH-1-k] : st_v[k];
        end
        for (int k = 0; k < DATA_WIDTH; k++) begin
            data_out[k] = REVERSE ? dout_v[DATA_WIDTH-1-k] : dout_v[k];
        end
    end

endmodule

// File: rtl/lfsr_prbs_err_cnt.sv
// Saturating up-counter with synchronous clear and a variable increment.
module lfsr_prbs_err_cnt
    import lfsr_prbs_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter int INC_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 inc_en,
    input  logic [INC_WIDTH-1:0] inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;
    logic [CNT_WIDTH:0]   sum_s;

    // Clear wins over a same-cycle increment; a carry out pins the count at all-ones.
    always_comb begin
        sum_s = {1'b0, count_q} + (CNT_WIDTH+1)'(inc);
        if (clear) begin
            count_d = {CNT_WIDTH{1'b0}};
        end else if (inc_en) begin
            if (sum_s[CNT_WIDTH]) begin
                count_d = {CNT_WIDTH{1'b1}};
            end else begin
                count_d = sum_s[CNT_WIDTH-1:0];
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CNT_WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/lfsr_prbs_check.sv
// PRBS receive checker: self-synchronising hunt, lock qualification, flywheel
// checking with windowed loss-of-lock and saturating error/word counters.
// Define LFSR_PRBS_CHECK_BIT_CNT_EN to make err_count count bit errors.
module lfsr_prbs_check
    import lfsr_prbs_pkg::*;
#(
    parameter int                    LFSR_WIDTH  = 9,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 9'h021,
    parameter                        LFSR_CONFIG = "FIBONACCI",
    parameter bit                    REVERSE     = 1'b0,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    LOCK_COUNT  = 4,
    parameter int                    LOSS_WINDOW = 16,
    parameter int                    LOSS_THRESH = 4,
    parameter int                    CNT_WIDTH   = 32
) (
    input logic               clk,
    input logic               rst_n,
    lfsr_prbs_check_if.slave  bus
);

    localparam int FILL_WORDS = fill_words(LFSR_WIDTH, DATA_WIDTH);
    localparam int FILL_W     = $clog2(FILL_WORDS + 1);
    localparam int GOOD_W     = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W      = $clog2(LOSS_WINDOW + 1);
    localparam int WERR_W     = $clog2(LOSS_THRESH + 1);
    localparam int INC_W      = $clog2(DATA_WIDTH + 1);

    prbs_state_e           state_q, state_d;
    logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
    logic [FILL_W-1:0]     fill_q, fill_d;
    logic [GOOD_W-1:0]     good_q, good_d;
    logic [WIN_W-1:0]      win_q, win_d;
    logic [WERR_W-1:0]     werr_q, werr_d;
    logic                  locked_q, word_error_q, word_error_d;
    logic [DATA_WIDTH-1:0] err_bits_q, err_bits_d;

    logic [DATA_WIDTH-1:0] exp_word_s;
    logic [LFSR_WIDTH-1:0] gen_state_s;
    logic [LFSR_WIDTH-1:0] sync_state_s;
    logic [DATA_WIDTH-1:0] sync_data_unused_s;
    logic [DATA_WIDTH-1:0] diff_s;
    logic                  mismatch_s;
    logic                  err_inc_en_s;
    logic                  word_inc_en_s;
    logic [INC_W-1:0]      err_inc_s;
    logic [CNT_WIDTH-1:0]  err_count_s;
    logic [CNT_WIDTH-1:0]  word_count_s;

    lfsr #(
        .LFSR_WIDTH(LFSR_WIDTH), .LFSR_POLY(LFSR_POLY), .LFSR_CONFIG(LFSR_CONFIG),
        .LFSR_FEED_FORWARD(1'b0), .REVERSE(REVERSE), .DATA_WIDTH(DATA_WIDTH)
    ) u_gen (
        .data_in   ({DATA_WIDTH{1'b0}}),
        .state_in  (lfsr_q),
        .data_out  (exp_word_s),
        .state_out (gen_state_s)
    );

    lfsr #(
        .LFSR_WIDTH(LFSR_WIDTH), .LFSR_POLY(LFSR_POLY), .LFSR_CONFIG(LFSR_CONFIG),
        .LFSR_FEED_FORWARD(1'b1), .REVERSE(REVERSE), .DATA_WIDTH(DATA_WIDTH)
    ) u_sync (
        .data_in   (bus.data_in),
        .state_in  (lfsr_q),
        .data_out  (sync_data_unused_s),
        .state_out (sync_state_s)
    );

    assign diff_s     = bus.data_in ^ exp_word_s;
    assign mismatch_s = |diff_s;

`ifdef LFSR_PRBS_CHECK_BIT_CNT_EN
    assign err_inc_s = INC_W'(popcount(64'(diff_s)));
`else
    assign err_inc_s = INC_W'(1'b1);
`endif

    // Next-state logic; idle cycles leave everything untouched.
    always_comb begin
        state_d       = state_q;
        lfsr_d        = lfsr_q;
        fill_d        = fill_q;
        good_d        = good_q;
        win_d         = win_q;
        werr_d        = werr_q;
        word_error_d  = 1'b0;
        err_bits_d    = {DATA_WIDTH{1'b0}};
        err_inc_en_s  = 1'b0;
        word_inc_en_s = 1'b0;
        if (!bus.enable) begin
            state_d = HUNT;
            fill_d  = {FILL_W{1'b0}};
            good_d  = {GOOD_W{1'b0}};
            win_d   = {WIN_W{1'b0}};
            werr_d  = {WERR_W{1'b0}};
        end else if (bus.data_in_valid) begin
            case (state_q)
                HUNT: begin
                    lfsr_d = sync_state_s;
                    fill_d = fill_q + FILL_W'(1'b1);
                    if (fill_d == FILL_W'(FILL_WORDS)) begin
                        state_d = CHECK;
                        good_d  = {GOOD_W{1'b0}};
                    end else begin
                        state_d = HUNT;
                    end
                end
                CHECK: begin
                    lfsr_d = gen_state_s;
                    if (mismatch_s) begin
                        word_error_d = 1'b1;
                        err_bits_d   = diff_s;
                        state_d      = HUNT;
                        fill_d       = {FILL_W{1'b0}};
                    end else begin
                        good_d = good_q + GOOD_W'(1'b1);
                        if (good_d == GOOD_W'(LOCK_COUNT)) begin
                            state_d = LOCKED;
                            win_d   = {WIN_W{1'b0}};
                            werr_d  = {WERR_W{1'b0}};
                        end else begin
                            state_d = CHECK;
                        end
                    end
                end
                LOCKED: begin
                    // Flywheel: the prediction is never reseeded from received data.
                    lfsr_d        = gen_state_s;
                    word_inc_en_s = 1'b1;
                    win_d         = win_q + WIN_W'(1'b1);
                    if (mismatch_s) begin
                        word_error_d = 1'b1;
                        err_bits_d   = diff_s;
                        err_inc_en_s = 1'b1;
                        werr_d       = werr_q + WERR_W'(1'b1);
                    end else begin
                        werr_d = werr_q;
                    end
                    if (werr_d == WERR_W'(LOSS_THRESH)) begin
                        state_d = HUNT;
                        fill_d  = {FILL_W{1'b0}};
                        win_d   = {WIN_W{1'b0}};
                        werr_d  = {WERR_W{1'b0}};
                    end else if (win_d == WIN_W'(LOSS_WINDOW)) begin
                        win_d  = {WIN_W{1'b0}};
                        werr_d = {WERR_W{1'b0}};
                    end else begin
                        state_d = LOCKED;
                    end
                end
                default: begin
                    state_d = HUNT;
                    fill_d  = {FILL_W{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM, predictor and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            lfsr_q       <= {LFSR_WIDTH{1'b0}};
            fill_q       <= {FILL_W{1'b0}};
            good_q       <= {GOOD_W{1'b0}};
            win_q        <= {WIN_W{1'b0}};
            werr_q       <= {WERR_W{1'b0}};
            locked_q     <= 1'b0;
            word_error_q <= 1'b0;
            err_bits_q   <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            fill_q       <= fill_d;
            good_q       <= good_d;
            win_q        <= win_d;
            werr_q       <= werr_d;
            locked_q     <= (state_d == LOCKED);
            word_error_q <= word_error_d;
            err_bits_q   <= err_bits_d;
        end
    end

    lfsr_prbs_err_cnt #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(INC_W)) u_err_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (bus.clear_counts),
        .inc_en (err_inc_en_s),
        .inc    (err_inc_s),
        .count  (err_count_s)
    );

    lfsr_prbs_err_cnt #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(INC_W)) u_word_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (bus.clear_counts),
        .inc_en (word_inc_en_s),
        .inc    (INC_W'(1'b1)),
        .count  (word_count_s)
    );

    assign bus.locked     = locked_q;
    assign bus.word_error = word_error_q;
    assign bus.err_bits   = err_bits_q;
    assign bus.err_count  = err_count_s;
    assign bus.word_count = word_count_s;

endmodule

// File: tb/tb_lfsr_prbs_check.sv
// Directed bench for lfsr_prbs_check: a PRBS9 stream with injected errors
// exercises sync, lock, loss of lock, counters, enable and reset.
module tb_lfsr_prbs_check;

    localparam int DW = 8;
    localparam int CW = 8;

`ifdef LFSR_PRBS_CHECK_BIT_CNT_EN
    localparam logic [31:0] FF_INC = 32'd8;
`else
    localparam logic [31:0] FF_INC = 32'd1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   err_seen = 0;
    logic [8:0] prbs_s = 9'h1FF;

    always #5 clk = ~clk;

    lfsr_prbs_check_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    lfsr_prbs_check #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Next 8 bits of x^9+x^5+1, first bit in the MSB.
    task automatic next_word(output logic [7:0] w);
        logic y;
        w = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            y      = prbs_s[8] ^ prbs_s[4];
            prbs_s = {prbs_s[7:0], y};
            w[i]   = y;
        end
    endtask

    task automatic send_raw(input logic [7:0] w);
        @(negedge clk);
        bus.data_in       = w;
        bus.data_in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.data_in_valid = 1'b0;
        if (bus.word_error) err_seen++;
    endtask

    task automatic send(input logic [7:0] flip);
        logic [7:0] w;
        next_word(w);
        send_raw(w ^ flip);
    endtask

    task automatic send_clean(input int n);
        for (int i = 0; i < n; i++) send(8'h00);
    endtask

    initial begin
        bus.enable        = 1'b1;
        bus.data_in       = 8'h00;
        bus.data_in_valid = 1'b0;
        bus.clear_counts  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_locked", 32'(bus.locked), 32'd0);
        check_val("rst_word_error", 32'(bus.word_error), 32'd0);
        check_val("rst_err_bits", 32'(bus.err_bits), 32'd0);
        check_val("rst_err_count", 32'(bus.err_count), 32'd0);
        check_val("rst_word_count", 32'(bus.word_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean sync: 2 fill + 4 check words.
        send_clean(5);
        check_val("lock_after_5", 32'(bus.locked), 32'd0);
        send(8'h00);
        check_val("lock_after_6", 32'(bus.locked), 32'd1);
        err_seen = 0;
        send_clean(100);
        check_val("clean_err_pulses", 32'(err_seen), 32'd0);
        check_val("clean_err_count", 32'(bus.err_count), 32'd0);
        check_val("clean_word_count", 32'(bus.word_count), 32'd100);

        // Single bit error while locked.
        send(8'h08);
        check_val("bit3_word_error", 32'(bus.word_error), 32'd1);
        check_val("bit3_err_bits", 32'(bus.err_bits), 32'h08);
        check_val("bit3_err_count", 32'(bus.err_count), 32'd1);
        check_val("bit3_locked", 32'(bus.locked), 32'd1);
        send(8'h00);
        check_val("bit3_pulse_once", 32'(bus.word_error), 32'd0);
        send_clean(10);
        check_val("align_word_count", 32'(bus.word_count), 32'd112);

        // Four errors inside one fresh window drop lock.
        send(8'h01);
        send(8'h02);
        send(8'h04);
        check_val("loss_after_3", 32'(bus.locked), 32'd1);
        send(8'h80);
        check_val("loss_locked", 32'(bus.locked), 32'd0);
        check_val("loss_word_error", 32'(bus.word_error), 32'd1);
        check_val("loss_err_count", 32'(bus.err_count), 32'd5);
        check_val("loss_word_count", 32'(bus.word_count), 32'd116);
        send_clean(5);
        check_val("relock_after_5", 32'(bus.locked), 32'd0);
        send(8'h00);
        check_val("relock_after_6", 32'(bus.locked), 32'd1);

        // enable low drops lock, counters hold.
        @(negedge clk);
        bus.enable = 1'b0;
        @(posedge clk);
        #1;
        check_val("dis_locked", 32'(bus.locked), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_val("dis_err_count", 32'(bus.err_count), 32'd5);
        check_val("dis_word_count", 32'(bus.word_count), 32'd116);
        @(negedge clk);
        bus.enable = 1'b1;

        // Error on the 3rd CHECK word returns to HUNT.
        send_clean(4);
        send(8'h30);
        check_val("chk_word_error", 32'(bus.word_error), 32'd1);
        check_val("chk_err_bits", 32'(bus.err_bits), 32'h30);
        check_val("chk_err_count", 32'(bus.err_count), 32'd5);
        check_val("chk_locked", 32'(bus.locked), 32'd0);
        send_clean(5);
        check_val("chk_relock_5", 32'(bus.locked), 32'd0);
        send(8'h00);
        check_val("chk_relock_6", 32'(bus.locked), 32'd1);

        // Saturation: one error every 8 words never threatens lock.
        for (int k = 0; k < 252; k++) begin
            send(8'h01);
            send_clean(7);
        end
        check_val("sat_err_count", 32'(bus.err_count), 32'hFF);
        check_val("sat_word_count", 32'(bus.word_count), 32'hFF);
        check_val("sat_locked", 32'(bus.locked), 32'd1);
        send_clean(16);

        // clear_counts beats a simultaneous increment.
        bus.clear_counts = 1'b1;
        send(8'h01);
        bus.clear_counts = 1'b0;
        check_val("clr_word_error", 32'(bus.word_error), 32'd1);
        check_val("clr_err_count", 32'(bus.err_count), 32'd0);
        check_val("clr_word_count", 32'(bus.word_count), 32'd0);
        send(8'hFF);
        check_val("ff_err_bits", 32'(bus.err_bits), 32'hFF);
        check_val("ff_err_count", 32'(bus.err_count), FF_INC);
        check_val("ff_word_count", 32'(bus.word_count), 32'd1);
        check_val("ff_locked", 32'(bus.locked), 32'd1);

        // Asynchronous reset mid-cycle.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_locked", 32'(bus.locked), 32'd0);
        check_val("arst_err_count", 32'(bus.err_count), 32'd0);
        check_val("arst_word_count", 32'(bus.word_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // All-zero input seeds the lockup state and shows false lock.
        for (int i = 0; i < 6; i++) send_raw(8'h00);
        check_val("zero_false_lock", 32'(bus.locked), 32'd1);
        check_val("zero_err_count", 32'(bus.err_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lfsr_prbs_check.md
Name: lfsr_prbs_check

Overview:
- Sequential PRBS checker built around the combinational lfsr module.
- Hunts for sync on an incoming word stream, then verifies lock, tracks lock state and counts errors.
- Sits at the receive side of link test / BIST paths, paired with an lfsr-based PRBS generator.

Parameters:
- LFSR_WIDTH, 9, PRBS state width.
- LFSR_POLY, 9'h021, feedback polynomial (PRBS9).
- LFSR_CONFIG, "FIBONACCI", passed to both lfsr instances.
- REVERSE, 0, bit order, passed to both lfsr instances.
- DATA_WIDTH, 8, received word width.
- LOCK_COUNT, 4, consecutive clean words in CHECK needed to declare lock.
- LOSS_WINDOW, 16, words per loss-of-lock evaluation window.
- LOSS_THRESH, 4, errored words within one window that drop lock.
- CNT_WIDTH, 32, width of the error and word counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  0 forces HUNT and holds the counters.
- data_in  in  DATA_WIDTH  received word.
- data_in_valid  in  1  data_in qualifier; there is no backpressure.
- clear_counts  in  1  synchronous clear of err_count and word_count.
- locked  out  1  high in LOCKED.
- word_error  out  1  one-cycle pulse: the checked word mismatched (CHECK or LOCKED only).
- err_bits  out  DATA_WIDTH  XOR of received and expected word; valid with word_error.
- err_count  out  CNT_WIDTH  saturating error counter.
- word_count  out  CNT_WIDTH  saturating count of words checked while LOCKED.

Behaviour:
Reset and outputs:
- Reset: the following clear to 0, and the FSM goes to HUNT:
  - state register, fill counter, good counter, window counter and window error counter;
  - locked, word_error, err_bits, err_count, word_count.
- All outputs are registered; word_error and err_bits appear 1 cycle after the valid input word.
- No state changes on a cycle with data_in_valid=0.

lfsr instances:
- gen: LFSR_FEED_FORWARD=0, data_in=0, state_in=state_reg. Its data_out is the expected word and its state_out is the predicted next state.
- sync: LFSR_FEED_FORWARD=1, data_in=received word, state_in=state_reg. Its state_out is the self-synchronised state.

FSM:
- HUNT:
  - Each valid word: state_reg <= sync.state_out; fill counter +1.
  - After FILL_WORDS = ceil(LFSR_WIDTH/DATA_WIDTH) words (2 for the defaults), go to CHECK and clear the good counter.
  - No comparisons are made in HUNT.
- CHECK:
  - Each valid word: compare against gen.data_out; state_reg <= gen.state_out.
  - Mismatch: pulse word_error, return to HUNT, clear the fill counter.
  - Match: good counter +1; on reaching LOCK_COUNT, go to LOCKED and clear the window counters.
- LOCKED:
  - Each valid word: state_reg <= gen.state_out (the flywheel; never reseeded from data); word_count +1; window counter +1.
  - Mismatch: word_error pulse; err_count increments; window error counter +1.
  - When window errors reach LOSS_THRESH before LOSS_WINDOW words have elapsed: go to HUNT, locked drops the next cycle.
  - Otherwise, at window end, both window counters clear.
- enable=0: from any state, go to HUNT on the next clock; counters hold; no word_error pulses.

Counters and boundaries:
- err_count and word_count saturate at all-ones.
- clear_counts takes priority over an increment in the same cycle, so the result is 0.
- A word whose mismatch triggers loss of lock is still counted and pulsed.
- All-zero input in HUNT seeds the all-zero lockup state. The checker then shows false lock on all-zero data, which is the documented behaviour.
- Asserting rst_n mid-operation aborts immediately.

Optional Feature:
- Macro LFSR_PRBS_CHECK_BIT_CNT_EN.
- Defined: err_count adds popcount(err_bits) per errored word (bit-error count, saturating).
- Undefined: err_count adds 1 per errored word.
- Ports and all other behaviour are identical in both builds.

Decomposition:
- Package lfsr_prbs_pkg holds:
  - the state enum (HUNT, CHECK, LOCKED);
  - a FILL_WORDS function of LFSR_WIDTH and DATA_WIDTH;
  - a popcount function.
- Natural sub-module: lfsr_prbs_err_cnt, the saturating counter with clear and variable increment, instantiated twice.
- The two lfsr instances are direct instantiations, not a new wrapper.

Test Plan:
- Clean sync: feed a PRBS9 stream (9'h021, seed 9'h1FF, 8-bit words).
  - locked rises after 2+4 = 6 valid words plus 1 cycle.
  - After 100 further words: err_count=0, word_count=100.
- Single bit error while locked: flip bit 3 of one word.
  - word_error pulses once with err_bits=8'h08; err_count=1; locked stays high.
  - With the macro, err_count=1 as well.
- Loss of lock: corrupt 4 words within a 16-word window.
  - locked falls the cycle after the 4th error and the FSM re-hunts.
  - Relock occurs within 6 clean words.
- Error during CHECK: corrupt the 3rd word after fill.
  - Returns to HUNT; locked never asserts; err_count unchanged.
- Counters: with err_count preloaded near saturation via forced errors, it holds at all-ones.
  - clear_counts asserted with a simultaneous error yields err_count=0.
  - Bit-count build: a word with err_bits=8'hFF adds 8.
- Reset and enable mid-lock:
  - rst_n low asynchronously clears locked and the counters.
  - enable=0 for 3 cycles drops lock with counters held; relock after re-enable.
